monitor_contador: RTL and testbench
===================================

MONITOR_CONTADOR -- requirements
Module: monitor_contador

Interface
REQ-001 The block SHALL have parameter ERR_W, default 8, giving the width of the error counter.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESET_N, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port ENB, input, 1 bit: counter enable as driven to the observed counter.
REQ-005 The block SHALL have port MODO, input, 2 bits: counter mode as driven to the observed counter.
REQ-006 The block SHALL have port D, input, 4 bits: parallel-load data as driven to the observed counter.
REQ-007 The block SHALL have port Q, input, 4 bits: observed counter output.
REQ-008 The block SHALL have port RCO, input, 1 bit: observed counter ripple-carry output.
REQ-009 The block SHALL have port CLR, input, 1 bit: synchronous clear of all results; returns the block to SYNC.
REQ-010 The block SHALL have port ERR, output, 1 bit: one-cycle pulse per detected mismatch.
REQ-011 The block SHALL have port STICKY_ERR, output, 1 bit: set on first mismatch, held until reset or CLR.
REQ-012 The block SHALL have port ERR_CNT, output, ERR_W bits: mismatch count, saturating.
REQ-013 The block SHALL have port FIRST_EXP, output, 4 bits: expected Q at the first mismatch.
REQ-014 The block SHALL have port FIRST_OBS, output, 4 bits: observed Q at the first mismatch.
REQ-015 The block SHALL have port FIRST_MODO, output, 2 bits: MODO in effect on the edge that produced the first mismatch.

Function
REQ-016 The golden model SHALL compute next Q mod 16 as follows: MODO 00 gives Q+1, 01 gives Q-1, 10 gives Q-3, 11 gives D.
REQ-017 The golden model SHALL compute next RCO as 1 iff Q equals 4'hF before the edge, regardless of MODO.
REQ-018 With ENB=0 on an edge, the model SHALL hold its expected Q and expected RCO unchanged.
REQ-019 The expected values for edge n+1 SHALL always be computed from the observed Q and RCO at edge n, so each fault is reported once and does not cascade.
REQ-020 The state machine SHALL have three states:
- SYNC: reset or CLR; no compare on the first edge; the model is loaded from the observed values; next state TRACK.
- TRACK: compare every edge; a mismatch moves to FAIL.
- FAIL: compare and count continue; leaves only on CLR or reset.
REQ-021 A mismatch SHALL be defined as Q differing from the expected Q, or RCO differing from the expected RCO (see REQ-028).
REQ-022 ERR SHALL be registered, asserting exactly one cycle after the edge on which the mismatching Q/RCO was sampled.
REQ-023 ERR_CNT SHALL increment by 1 per mismatch and saturate at 2^ERR_W-1 without wrap.
REQ-024 FIRST_EXP, FIRST_OBS and FIRST_MODO SHALL be captured only on the TRACK-to-FAIL transition and frozen thereafter.
REQ-025 Wrap-around SHALL be modelled: 15+1 gives 0; 0-1 gives 15; 1-3 gives 14; 2-3 gives 15.
REQ-026 CLR asserted on the same edge as a mismatch SHALL take priority: the mismatch is not counted and the state becomes SYNC.

Reset
REQ-027 While RESET_N=0, the block SHALL force the following values asynchronously:
- state = SYNC;
- ERR = 0, STICKY_ERR = 0, ERR_CNT = 0;
- FIRST_EXP = 0, FIRST_OBS = 0, FIRST_MODO = 0;
- model registers = 0.
Reset deasserted mid-sequence SHALL resume in SYNC, with no compare on the first edge.

Configuration
REQ-028 Macro MONITOR_RCO_CHECK_EN SHALL control RCO checking:
- defined: RCO mismatches count per REQ-021;
- undefined: only Q is compared, the RCO model is removed, and the RCO input is ignored.

Structure
REQ-029 Package monitor_contador_pkg SHALL hold the following:
- state encoding (SYNC, TRACK, FAIL);
- mode constants MODO_UP=00, MODO_DOWN=01, MODO_DOWN3=10, MODO_LOAD=11;
- counter width constant 4.
REQ-030 The next-value function (REQ-016 to REQ-018) SHALL live in sub-module modelo_contador.

Verification
REQ-031 Reset, then MODO=00 and ENB=1 for 20 edges with a correct counter → Q sequence 0..15,0..3; RCO=1 on the edge after Q=15; ERR never set; ERR_CNT=0.
REQ-032 MODO=10 from Q=2 with a correct counter → Q=15, then 12; no error; RCO=1 on the edge after Q=15.
REQ-033 Inject Q=5 where 4 is expected in MODO=00 → ERR pulses once; ERR_CNT=1; FIRST_EXP=4, FIRST_OBS=5, FIRST_MODO=00; the next edge expects 6, with no second error.
REQ-034 Force RCO=0 after Q=15 → ERR_CNT=1 with MONITOR_RCO_CHECK_EN defined; ERR_CNT=0 without it.
REQ-035 Set ERR_W=2 and inject 5 mismatches → ERR_CNT saturates at 3; CLR coincident with a 6th mismatch gives ERR_CNT=0, STICKY_ERR=0, state SYNC.
REQ-036 Set ENB=0 for 3 edges with Q held at 9, then MODO=11, D=4'hA → no error; Q=10 expected; pulse RESET_N low mid-run → all outputs 0 immediately.

Source files
------------

// File: rtl/monitor_contador_pkg.sv
// Shared state encoding and mode constants for the counter monitor.
// RCO checking is enabled by defining MONITOR_RCO_CHECK_EN.
package monitor_contador_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAIL  = 2'd2
  } estado_t;

  localparam logic [1:0] MODO_UP    = 2'b00;
  localparam logic [1:0] MODO_DOWN  = 2'b01;
  localparam logic [1:0] MODO_DOWN3 = 2'b10;
  localparam logic [1:0] MODO_LOAD  = 2'b11;

endpackage

// File: rtl/modelo_contador.sv
// Golden model of the observed counter: next expected Q (and RCO).
// RCO model exists only when MONITOR_RCO_CHECK_EN is defined.
module modelo_contador
  import monitor_contador_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enb,
  input  logic [1:0] modo,
  input  cnt_t       d,
  input  cnt_t       q,
`ifdef MONITOR_RCO_CHECK_EN
  input  logic       rco,
  output logic       exp_rco,
`endif
  output cnt_t       exp_q
);

  cnt_t q_nxt;

  // Always built from the observed values so a fault never cascades
  always_comb begin
    q_nxt = q;
    if (enb) begin
      unique case (modo)
        MODO_UP:    q_nxt = q + cnt_t'(1);
        MODO_DOWN:  q_nxt = q - cnt_t'(1);
        MODO_DOWN3: q_nxt = q - cnt_t'(3);
        default:    q_nxt = d;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= '0;
    end else begin
      exp_q <= q_nxt;
    end
  end

`ifdef MONITOR_RCO_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_rco <= 1'b0;
    end else begin
      exp_rco <= enb ? (q == '1) : rco;
    end
  end
`endif

endmodule

// File: rtl/monitor_contador.sv
// Monitor comparing a 4-bit counter against a golden model.
// Define MONITOR_RCO_CHECK_EN to also compare RCO.
module monitor_contador
  import monitor_contador_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic [3:0]       D,
  input  logic [3:0]       Q,
  input  logic             RCO,
  input  logic             CLR,
  output logic             ERR,
  output logic             STICKY_ERR,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [3:0]       FIRST_EXP,
  output logic [3:0]       FIRST_OBS,
  output logic [1:0]       FIRST_MODO
);

  estado_t    estado;
  cnt_t       exp_q;
  logic [1:0] exp_modo;
  logic       mism;
  logic       cnt_max;

`ifdef MONITOR_RCO_CHECK_EN
  logic exp_rco;

  modelo_contador u_modelo (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .enb     (ENB),
    .modo    (MODO),
    .d       (D),
    .q       (Q),
    .rco     (RCO),
    .exp_rco (exp_rco),
    .exp_q   (exp_q)
  );

  assign mism = (Q != exp_q) || (RCO != exp_rco);
`else
  logic unused_rco;
  assign unused_rco = RCO;

  modelo_contador u_modelo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .enb   (ENB),
    .modo  (MODO),
    .d     (D),
    .q     (Q),
    .exp_q (exp_q)
  );

  assign mism = (Q != exp_q);
`endif

  assign cnt_max = &ERR_CNT;

  // Mode that produced the value compared on the next edge
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      exp_modo <= '0;
    end else begin
      exp_modo <= MODO;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      estado     <= SYNC;
      ERR        <= 1'b0;
      STICKY_ERR <= 1'b0;
      ERR_CNT    <= '0;
      FIRST_EXP  <= '0;
      FIRST_OBS  <= '0;
      FIRST_MODO <= '0;
    end else if (CLR) begin
      estado     <= SYNC;
      ERR        <= 1'b0;
      STICKY_ERR <= 1'b0;
      ERR_CNT    <= '0;
      FIRST_EXP  <= '0;
      FIRST_OBS  <= '0;
      FIRST_MODO <= '0;
    end else begin
      ERR <= 1'b0;
      unique case (estado)
        SYNC: estado <= TRACK;
        TRACK: begin
          if (mism) begin
            estado     <= FAIL;
            ERR        <= 1'b1;
            STICKY_ERR <= 1'b1;
            FIRST_EXP  <= exp_q;
            FIRST_OBS  <= Q;
            FIRST_MODO <= exp_modo;
            if (!cnt_max) ERR_CNT <= ERR_CNT + ERR_W'(1);
          end
        end
        FAIL: begin
          if (mism) begin
            ERR <= 1'b1;
            if (!cnt_max) ERR_CNT <= ERR_CNT + ERR_W'(1);
          end
        end
        default: estado <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_monitor_contador.sv
// Bench for monitor_contador: a behavioural counter with fault injection
// drives two monitors (default width and ERR_W=2).
module tb_monitor_contador;

`ifdef MONITOR_RCO_CHECK_EN
  localparam bit RCO_EN = 1'b1;
`else
  localparam bit RCO_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       ENB = 1'b0;
  logic [1:0] MODO = 2'b00;
  logic [3:0] D = 4'h0;
  logic [3:0] Q = 4'h0;
  logic       RCO = 1'b0;
  logic       CLR = 1'b0;

  logic       ERR, STICKY_ERR;
  logic [7:0] ERR_CNT;
  logic [3:0] FIRST_EXP, FIRST_OBS;
  logic [1:0] FIRST_MODO;

  logic       err2, sticky2;
  logic [1:0] cnt2;
  logic [3:0] fexp2, fobs2;
  logic [1:0] fmodo2;

  monitor_contador u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENB(ENB), .MODO(MODO), .D(D),
    .Q(Q), .RCO(RCO), .CLR(CLR), .ERR(ERR), .STICKY_ERR(STICKY_ERR),
    .ERR_CNT(ERR_CNT), .FIRST_EXP(FIRST_EXP), .FIRST_OBS(FIRST_OBS),
    .FIRST_MODO(FIRST_MODO)
  );

  monitor_contador #(.ERR_W(2)) u_dut_w2 (
    .CLK(CLK), .RESET_N(RESET_N), .ENB(ENB), .MODO(MODO), .D(D),
    .Q(Q), .RCO(RCO), .CLR(CLR), .ERR(err2), .STICKY_ERR(sticky2),
    .ERR_CNT(cnt2), .FIRST_EXP(fexp2), .FIRST_OBS(fobs2),
    .FIRST_MODO(fmodo2)
  );

  always #5 CLK = ~CLK;

  int compared = 0;
  int mismatched = 0;

  // True counter state (what a healthy counter would show next)
  logic [3:0] cur_q = 4'h0;
  logic       cur_rco = 1'b0;
  // Expected monitor results
  bit         m_sync = 1'b1;
  bit         m_fail = 1'b0;
  bit         m_err = 1'b0;
  int         m_cnt = 0;
  logic [3:0] m_fe = 4'h0;
  logic [3:0] m_fo = 4'h0;
  logic [1:0] m_fm = 2'b00;
  logic [1:0] prev_modo = 2'b00;
  bit         prev_enb = 1'b0;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("err", 32'(ERR), 32'(m_err));
    chk("sticky", 32'(STICKY_ERR), 32'(m_fail));
    chk("err_cnt", 32'(ERR_CNT), 32'(sat(m_cnt, 255)));
    chk("first_exp", 32'(FIRST_EXP), 32'(m_fe));
    chk("first_obs", 32'(FIRST_OBS), 32'(m_fo));
    chk("first_modo", 32'(FIRST_MODO), 32'(m_fm));
    chk("err_w2", 32'(err2), 32'(m_err));
    chk("sticky_w2", 32'(sticky2), 32'(m_fail));
    chk("err_cnt_w2", 32'(cnt2), 32'(sat(m_cnt, 3)));
    chk("first_exp_w2", 32'(fexp2), 32'(m_fe));
  endtask

  // One clock edge: qf/rf are XOR fault masks on the shown Q/RCO
  task automatic step(input logic enb, input logic [1:0] modo,
                      input logic [3:0] d, input logic clr,
                      input logic [3:0] qf, input logic rf);
    logic [3:0] qd;
    logic       rd;
    bit         mism;
    @(negedge CLK);
    qd = cur_q ^ qf;
    rd = cur_rco ^ rf;
    RESET_N = 1'b1;
    ENB = enb; MODO = modo; D = d; CLR = clr; Q = qd; RCO = rd;
    @(posedge CLK);
    mism = !m_sync && ((qf != 4'h0) || (RCO_EN && rf));
    if (clr) begin
      m_sync = 1'b1; m_fail = 1'b0; m_err = 1'b0; m_cnt = 0;
      m_fe = 4'h0; m_fo = 4'h0; m_fm = 2'b00;
    end else begin
      m_sync = 1'b0;
      m_err = mism;
      if (mism) begin
        m_cnt++;
        if (!m_fail) begin
          m_fail = 1'b1; m_fe = cur_q; m_fo = qd; m_fm = prev_modo;
        end
      end
    end
    prev_modo = modo;
    prev_enb = enb;
    // A faulty counter carries on from the value it actually shows
    if (enb) begin
      cur_rco = (qd == 4'd15);
      case (modo)
        2'd0:    cur_q = 4'((int'(qd) + 1) % 16);
        2'd1:    cur_q = 4'((int'(qd) + 15) % 16);
        2'd2:    cur_q = 4'((int'(qd) + 13) % 16);
        default: cur_q = d;
      endcase
    end else begin
      cur_q = qd;
      cur_rco = rd;
    end
    #1 check_all();
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    m_sync = 1'b1; m_fail = 1'b0; m_err = 1'b0; m_cnt = 0;
    m_fe = 4'h0; m_fo = 4'h0; m_fm = 2'b00;
    check_all();
    chk("rst_first_modo_w2", 32'(fmodo2), 32'(0));
    chk("rst_first_obs_w2", 32'(fobs2), 32'(0));
  endtask

  initial begin
    logic       r_enb, r_clr, r_rf;
    logic [1:0] r_modo;
    logic [3:0] r_d, r_qf;

    do_reset();

    // Healthy up-count through the 15->0 wrap
    repeat (21) step(1'b1, 2'b00, 4'h0, 1'b0, 4'h0, 1'b0);
    chk("up_run_cnt", 32'(ERR_CNT), 32'(0));

    // Down-by-3 wrap from 2
    step(1'b1, 2'b11, 4'h2, 1'b0, 4'h0, 1'b0);
    step(1'b1, 2'b10, 4'h0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 2'b10, 4'h0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 2'b00, 4'h0, 1'b0, 4'h0, 1'b0);
    chk("down3_cnt", 32'(ERR_CNT), 32'(0));

    // Show 5 where 4 is expected
    step(1'b1, 2'b11, 4'h3, 1'b0, 4'h0, 1'b0);
    step(1'b1, 2'b00, 4'h0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 2'b00, 4'h0, 1'b0, 4'h1, 1'b0);
    chk("inj_err", 32'(ERR), 32'(1));
    chk("inj_cnt", 32'(ERR_CNT), 32'(1));
    chk("inj_first_exp", 32'(FIRST_EXP), 32'(4));
    chk("inj_first_obs", 32'(FIRST_OBS), 32'(5));
    chk("inj_first_modo", 32'(FIRST_MODO), 32'(0));
    step(1'b1, 2'b00, 4'h0, 1'b0, 4'h0, 1'b0);
    chk("inj_next_err", 32'(ERR), 32'(0));
    chk("inj_next_cnt", 32'(ERR_CNT), 32'(1));

    // RCO dropped after Q=15
    step(1'b1, 2'b11, 4'hF, 1'b1, 4'h0, 1'b0);
    step(1'b1, 2'b00, 4'h0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 2'b00, 4'h0, 1'b0, 4'h0, 1'b1);
    chk("rco_drop_cnt", 32'(ERR_CNT), RCO_EN ? 32'(1) : 32'(0));

    // Saturation of the narrow counter, then CLR on a mismatch
    step(1'b1, 2'b00, 4'h0, 1'b1, 4'h0, 1'b0);
    step(1'b1, 2'b00, 4'h0, 1'b0, 4'h0, 1'b0);
    repeat (5) step(1'b1, 2'b00, 4'h0, 1'b0, 4'h1, 1'b0);
    chk("sat_cnt_w2", 32'(cnt2), 32'(3));
    chk("sat_cnt", 32'(ERR_CNT), 32'(5));
    step(1'b1, 2'b00, 4'h0, 1'b1, 4'h1, 1'b0);
    chk("clr_cnt_w2", 32'(cnt2), 32'(0));
    chk("clr_sticky", 32'(STICKY_ERR), 32'(0));
    step(1'b1, 2'b00, 4'h0, 1'b0, 4'h3, 1'b0);
    chk("clr_sync_err", 32'(ERR), 32'(0));

    // Hold at 9, then load A
    step(1'b1, 2'b11, 4'h9, 1'b0, 4'h0, 1'b0);
    repeat (3) step(1'b0, 2'b00, 4'h0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 2'b11, 4'hA, 1'b0, 4'h0, 1'b0);
    step(1'b1, 2'b00, 4'h0, 1'b0, 4'h0, 1'b0);
    chk("hold_load_cnt", 32'(ERR_CNT), 32'(0));
    do_reset();

    // Random traffic with occasional faults, clears and resets
    repeat (400) begin
      r_enb  = ($urandom_range(0, 3) != 0);
      r_modo = 2'($urandom_range(0, 3));
      r_d    = 4'($urandom_range(0, 15));
      r_clr  = ($urandom_range(0, 31) == 0);
      r_qf   = (prev_enb && $urandom_range(0, 9) == 0)
               ? 4'($urandom_range(1, 15)) : 4'h0;
      r_rf   = prev_enb && ($urandom_range(0, 19) == 0);
      step(r_enb, r_modo, r_d, r_clr, r_qf, r_rf);
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
